// File: rtl/spi_mem_slave_if.sv
// Pin-level bundle of the SPI memory slave: the serial bus plus its status strobes.
interface spi_mem_slave_if;
  logic cs;
  logic sclk;
  logic mosi;
  logic miso;
  logic miso_oe;
  logic busy;
  logic xfer_done;
  logic frame_err;

  modport master (output cs, sclk, mosi, input miso, miso_oe, busy, xfer_done, frame_err);
  modport slave  (input cs, sclk, mosi, output miso, miso_oe, busy, xfer_done, frame_err);
endinterface

// File: rtl/spi_mem_slave.sv
// SPI slave exposing a 2**ADDR_W x DATA_W memory; all four SPI modes, bursts with address wrap.
// The SPI pins are oversampled in the clk domain, so SCLK must be much slower than clk.
module spi_mem_slave #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int CPOL   = 0,
  parameter int CPHA   = 0,
  parameter int SYNC   = 2
) (
  input logic           clk,
  input logic           rst_n,
  spi_mem_slave_if.slave bus
);

  localparam int CNT_W = $clog2((ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W);
  localparam logic [CNT_W-1:0] LAST_CMD  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
  localparam logic CPOL_L = 1'(CPOL);
  localparam logic CPHA_L = 1'(CPHA);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CMD     = 3'd1;
  localparam logic [2:0] S_RD_LOAD = 3'd2;
  localparam logic [2:0] S_READ    = 3'd3;
  localparam logic [2:0] S_WRITE   = 3'd4;

  logic [SYNC-1:0]   cs_q, sclk_q, mosi_q;
  logic              cs_prev, sclk_prev;
  logic [2:0]        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] cmd_sh;
  logic [DATA_W-1:0] sh;
  logic              wr_pend;
  logic              miso_r, miso_oe_r, xfer_done_r, frame_err_r;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic              cs_s, sclk_s, mosi_s;
  logic              cs_fall, sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
  logic [ADDR_W:0]   cmd_word;

  assign cs_s        = cs_q[SYNC-1];
  assign sclk_s      = sclk_q[SYNC-1];
  assign mosi_s      = mosi_q[SYNC-1];
  assign cs_fall     = cs_prev && !cs_s;
  assign sclk_edge   = sclk_s != sclk_prev;
  assign lead_edge   = sclk_edge && (sclk_s != CPOL_L);
  assign trail_edge  = sclk_edge && (sclk_s == CPOL_L);
  assign sample_edge = CPHA_L ? trail_edge : lead_edge;
  assign shift_edge  = CPHA_L ? lead_edge : trail_edge;
  assign cmd_word    = {cmd_sh, mosi_s};

  // CS chain resets low so a CS already asserted at reset release never looks like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_q      <= '0;
      sclk_q    <= {SYNC{CPOL_L}};
      mosi_q    <= '0;
      cs_prev   <= 1'b0;
      sclk_prev <= CPOL_L;
    end else begin
      cs_q      <= {cs_q[SYNC-2:0], bus.cs};
      sclk_q    <= {sclk_q[SYNC-2:0], bus.sclk};
      mosi_q    <= {mosi_q[SYNC-2:0], bus.mosi};
      cs_prev   <= cs_s;
      sclk_prev <= sclk_s;
    end
  end

  // NOTE: the memory array has no reset branch; its contents survive rst_n by design.
  always_ff @(posedge clk) begin
    if (wr_pend) mem[addr] <= sh;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      bit_cnt     <= '0;
      addr        <= '0;
      cmd_sh      <= '0;
      sh          <= '0;
      wr_pend     <= 1'b0;
      miso_r      <= 1'b0;
      miso_oe_r   <= 1'b0;
      xfer_done_r <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      xfer_done_r <= 1'b0;
      frame_err_r <= 1'b0;
      wr_pend     <= 1'b0;
      // A fully sampled write word commits even if CS rises in the same cycle.
      if (wr_pend) begin
        addr        <= addr + 1'b1;
        xfer_done_r <= 1'b1;
      end
      if (state != S_IDLE && cs_s) begin
        frame_err_r <= (bit_cnt != '0);
        state       <= S_IDLE;
        bit_cnt     <= '0;
        miso_r      <= 1'b0;
        miso_oe_r   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (cs_fall) begin
              state   <= S_CMD;
              bit_cnt <= '0;
            end
          end
          S_CMD: begin
            if (sample_edge) begin
              cmd_sh <= cmd_word[ADDR_W-1:0];
              if (bit_cnt == LAST_CMD) begin
                addr    <= cmd_word[ADDR_W-1:0];
                bit_cnt <= '0;
                state   <= cmd_word[ADDR_W] ? S_RD_LOAD : S_WRITE;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          S_RD_LOAD: begin
            sh    <= mem[addr];
            addr  <= addr + 1'b1;
            state <= S_READ;
          end
          S_READ: begin
            if (shift_edge) begin
              miso_r    <= sh[DATA_W-1];
              sh        <= {sh[DATA_W-2:0], 1'b0};
              miso_oe_r <= 1'b1;
            end
            if (sample_edge) begin
              if (bit_cnt == LAST_DATA) begin
                bit_cnt     <= '0;
                xfer_done_r <= 1'b1;
                state       <= S_RD_LOAD;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          S_WRITE: begin
            if (sample_edge) begin
              sh <= {sh[DATA_W-2:0], mosi_s};
              if (bit_cnt == LAST_DATA) begin
                bit_cnt <= '0;
                wr_pend <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.miso      = miso_r;
  assign bus.miso_oe   = miso_oe_r;
  assign bus.busy      = (state != S_IDLE);
  assign bus.xfer_done = xfer_done_r;
  assign bus.frame_err = frame_err_r;

endmodule

// File: tb/tb_spi_mem_slave.sv
// Directed bench for spi_mem_slave: a bit-banged SPI master, a memory model and a read scoreboard.
module tb_spi_mem_slave;

  localparam int  ADDR_W = 7;
  localparam int  DATA_W = 8;
  localparam int  CPOL   = 0;
  localparam int  CPHA   = 0;
  localparam time HALF   = 80;
  localparam logic IDLE_LVL = 1'(CPOL);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_mem_slave_if bus ();

  spi_mem_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CPOL(CPOL), .CPHA(CPHA), .SYNC(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;
  int xfer_cnt = 0;
  int ferr_cnt = 0;
  int oe_viol = 0;
  logic oe_zero = 1'b0;
  logic [DATA_W-1:0] model_mem [2**ADDR_W];
  logic [DATA_W-1:0] sb [$];
  logic [DATA_W-1:0] wq [$];

  // Strobe monitor counts high cycles, so an over-long pulse also shows up as extra counts.
  always @(negedge clk) begin
    if (bus.xfer_done === 1'b1) xfer_cnt++;
    if (bus.frame_err === 1'b1) ferr_cnt++;
    if (oe_zero && bus.miso_oe !== 1'b0) oe_viol++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer_bit(input logic o, output logic i);
    if (CPHA == 0) begin
      bus.mosi = o;
      #HALF;
      i = bus.miso;
      bus.sclk = ~IDLE_LVL;
      #HALF;
      bus.sclk = IDLE_LVL;
    end else begin
      bus.sclk = ~IDLE_LVL;
      bus.mosi = o;
      #HALF;
      i = bus.miso;
      bus.sclk = IDLE_LVL;
      #HALF;
    end
  endtask

  task automatic frame_start();
    bus.cs = 1'b0;
    #(2*HALF);
  endtask

  task automatic frame_end();
    #HALF;
    bus.cs = 1'b1;
    #(4*HALF);
  endtask

  task automatic send_bits(input logic [31:0] val, input int n);
    logic d;
    for (int i = n - 1; i >= 0; i--) xfer_bit(val[i], d);
  endtask

  task automatic spi_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] words[$]);
    logic [ADDR_W-1:0] aa;
    aa = a;
    oe_zero = 1'b1;
    frame_start();
    send_bits({24'd0, 1'b0, a}, ADDR_W + 1);
    check("wr_busy", bus.busy, 1);
    foreach (words[k]) begin
      send_bits({24'd0, words[k]}, DATA_W);
      model_mem[aa] = words[k];
      aa++;
    end
    frame_end();
    check("wr_idle_busy", bus.busy, 0);
    oe_zero = 1'b0;
  endtask

  task automatic spi_read(input logic [ADDR_W-1:0] a, input int n);
    logic [ADDR_W-1:0] aa;
    logic [DATA_W-1:0] word, exp;
    logic d;
    aa = a;
    for (int k = 0; k < n; k++) begin
      sb.push_back(model_mem[aa]);
      aa++;
    end
    oe_zero = 1'b1;
    frame_start();
    send_bits({24'd0, 1'b1, a}, ADDR_W + 1);
    oe_zero = 1'b0;
    for (int k = 0; k < n; k++) begin
      word = '0;
      for (int b = 0; b < DATA_W; b++) begin
        xfer_bit(1'b0, d);
        word = {word[DATA_W-2:0], d};
      end
      check("rd_oe", bus.miso_oe, 1);
      exp = sb.pop_front();
      check("rd_data", word, exp);
    end
    frame_end();
    check("rd_oe_after_cs", bus.miso_oe, 0);
  endtask

  int xs, fs;

  initial begin
    bus.cs   = 1'b1;
    bus.sclk = IDLE_LVL;
    bus.mosi = 1'b0;
    #102;
    check("rst_miso", bus.miso, 0);
    check("rst_oe", bus.miso_oe, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_xfer", bus.xfer_done, 0);
    check("rst_ferr", bus.frame_err, 0);
    rst_n = 1'b1;
    #100;

    // Single write then read-back.
    xs = xfer_cnt; fs = ferr_cnt;
    wq.delete(); wq.push_back(8'hA5);
    spi_write(7'h05, wq);
    check("t1_wr_xfer", xfer_cnt - xs, 1);
    xs = xfer_cnt;
    spi_read(7'h05, 1);
    check("t1_rd_xfer", xfer_cnt - xs, 1);
    check("t1_ferr", ferr_cnt - fs, 0);

    // Burst across the top of memory, then burst read through the wrap.
    xs = xfer_cnt;
    wq.delete(); wq.push_back(8'h11); wq.push_back(8'h22); wq.push_back(8'h33);
    spi_write(7'h7E, wq);
    check("t2_wr_xfer", xfer_cnt - xs, 3);
    xs = xfer_cnt;
    spi_read(7'h7E, 3);
    check("t2_rd_xfer", xfer_cnt - xs, 3);
    check("t2_ferr", ferr_cnt - fs, 0);

    // Aborted write word leaves memory untouched and flags one frame error.
    wq.delete(); wq.push_back(8'h3C);
    spi_write(7'h10, wq);
    xs = xfer_cnt; fs = ferr_cnt;
    oe_zero = 1'b1;
    frame_start();
    send_bits({24'd0, 1'b0, 7'h10}, ADDR_W + 1);
    send_bits(32'h1F, 5);
    frame_end();
    oe_zero = 1'b0;
    check("t3_ferr", ferr_cnt - fs, 1);
    check("t3_xfer", xfer_cnt - xs, 0);
    spi_read(7'h10, 1);

    // Abort inside the command phase.
    fs = ferr_cnt;
    frame_start();
    send_bits(32'h5, 3);
    frame_end();
    check("t3_cmd_ferr", ferr_cnt - fs, 1);
    wq.delete(); wq.push_back(8'h77);
    spi_write(7'h11, wq);
    spi_read(7'h11, 1);

    // Reset mid read word; CS held low across release must be ignored.
    frame_start();
    send_bits({24'd0, 1'b1, 7'h05}, ADDR_W + 1);
    send_bits(32'h0, 3);
    rst_n = 1'b0;
    #1;
    check("t5_miso", bus.miso, 0);
    check("t5_oe", bus.miso_oe, 0);
    check("t5_busy", bus.busy, 0);
    oe_zero = 1'b1;
    #49;
    rst_n = 1'b1;
    #40;
    send_bits(32'hA, 4);
    check("t5_busy_cs_low", bus.busy, 0);
    check("t5_oe_cs_low", bus.miso_oe, 0);
    frame_end();
    oe_zero = 1'b0;
    spi_read(7'h05, 1);

    check("oe_zero_viol", oe_viol, 0);
    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
